// File: rtl/keypad_entry_buffer.sv
// -----------------------------------------------------------------------------
// keypad_entry_buffer
//
// Purpose:
//   Collects single hex keystrokes from the keypad scanner into one
//   multi-digit guess word. The first digit typed ends up in the most
//   significant nibble. The block supports a backspace key, an explicit enter
//   key and an inactivity timeout. It accepts keys only while the game is in
//   its input phase.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   enable       in   high = input phase; low flushes the entry and forces IDLE
//   clear        in   synchronous flush request from game control
//   key_valid    in   one-cycle strobe per key press
//   key_code     in   hex code of the pressed key, qualified by key_valid
//   value        out  assembled guess, first-typed digit in the MS nibble
//   value_ready  out  one-cycle pulse: value holds a submitted guess
//   digit_count  out  digits currently held, 0..NUM_DIGITS
//   entry_error  out  one-cycle pulse on a rejected key
//   timeout      out  one-cycle pulse when a partial entry is discarded
// -----------------------------------------------------------------------------
module keypad_entry_buffer #(
  parameter int         NUM_DIGITS     = 4,
  parameter logic [3:0] ENTER_CODE     = 4'hF,
  parameter logic [3:0] BACK_CODE      = 4'hE,
  parameter int         TIMEOUT_CYCLES = 300000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_ready,
  output logic [2:0]              digit_count,
  output logic                    entry_error,
  output logic                    timeout
);

  localparam int         VW       = 4 * NUM_DIGITS;
  // A one-cycle timeout would give a zero-width counter; keep at least one bit.
  localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FULL    = 3'd2,
    DONE    = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  state_t          state_q;
  logic [VW-1:0]   value_q;
  logic [2:0]      cnt_q;
  logic            ready_q;
  logic            err_q;
  logic            tmo_q;
  logic [TW-1:0]   timer_q;

  logic            is_digit;
  logic            counting;
  logic            expire;
  logic [VW-1:0]   value_push;
  logic [VW-1:0]   value_pop;

  assign is_digit   = (key_code != ENTER_CODE) && (key_code != BACK_CODE);
  // Inactivity only matters while a partial or complete-but-unsubmitted
  // entry is held.
  assign counting   = (state_q == COLLECT) || (state_q == FULL);
  assign expire     = counting && (timer_q == TIMER_LAST);
  assign value_push = {value_q[VW-5:0], key_code};
  assign value_pop  = value_q >> 4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      value_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      // All three status outputs are single-cycle pulses.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;

      if (!enable || clear) begin
        // Flush silently; any coincident key is dropped.
        state_q <= IDLE;
        value_q <= '0;
        cnt_q   <= '0;
        timer_q <= '0;
      end else if (expire) begin
        // Timeout outranks a coincident key, which is dropped.
        state_q <= IDLE;
        value_q <= '0;
        cnt_q   <= '0;
        timer_q <= '0;
        tmo_q   <= 1'b1;
      end else if (key_valid) begin
        // Any key, accepted or rejected, counts as activity.
        timer_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (is_digit) begin
              value_q <= VW'(key_code);
              cnt_q   <= 3'd1;
              state_q <= (FULL_CNT == 3'd1) ? FULL : COLLECT;
            end else begin
              err_q <= 1'b1;
            end
          end
          COLLECT: begin
            if (is_digit) begin
              value_q <= value_push;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == FULL_CNT - 3'd1) state_q <= FULL;
            end else if (key_code == BACK_CODE) begin
              value_q <= value_pop;
              cnt_q   <= cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_q <= IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end
          FULL: begin
            if (key_code == ENTER_CODE) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else if (key_code == BACK_CODE) begin
              value_q <= value_pop;
              cnt_q   <= cnt_q - 3'd1;
              state_q <= (cnt_q == 3'd1) ? IDLE : COLLECT;
            end else begin
              err_q <= 1'b1;
            end
          end
          DONE: begin
            err_q   <= 1'b1;
            state_q <= LOCKED;
          end
          LOCKED: begin
            err_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
          end
        endcase
      end else begin
        if (counting) begin
          timer_q <= timer_q + TW'(1);
        end else begin
          timer_q <= '0;
        end
        // DONE lasts exactly one cycle, long enough for the ready pulse.
        if (state_q == DONE) state_q <= LOCKED;
      end
    end
  end

  assign value       = value_q;
  assign value_ready = ready_q;
  assign digit_count = cnt_q;
  assign entry_error = err_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
module tb_keypad_entry_buffer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic        value_ready;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        timeout;

  int checks;
  int errors;

  keypad_entry_buffer #(
    .NUM_DIGITS    (4),
    .ENTER_CODE    (4'hF),
    .BACK_CODE     (4'hE),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .value      (value),
    .value_ready(value_ready),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One key strobe; returns on the falling edge after the capturing edge.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; clear = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    #23;
    checks++;
    if ({value, digit_count, value_ready, entry_error, timeout} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got value=%h cnt=%0d rdy=%b err=%b tmo=%b required all 0",
               value, digit_count, value_ready, entry_error, timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_basic_entry();
    press(4'h1); press(4'h2); press(4'h3);
    checks++;
    if (value !== 16'h0123 || digit_count !== 3'd3) begin
      errors++;
      $display("FAIL basic_partial got %h/%0d required 0123/3", value, digit_count);
    end
    press(4'h4);
    checks++;
    if (value !== 16'h1234 || digit_count !== 3'd4 || value_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_full got %h/%0d rdy=%b required 1234/4 rdy=0", value, digit_count, value_ready);
    end
    press(4'hF);
    checks++;
    if (value_ready !== 1'b1 || value !== 16'h1234 || entry_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready got rdy=%b value=%h err=%b required rdy=1 value=1234 err=0",
               value_ready, value, entry_error);
    end
    @(negedge clk);
    checks++;
    if (value_ready !== 1'b0 || value !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_ready_once got rdy=%b value=%h cnt=%0d required rdy=0 value=1234 cnt=4",
               value_ready, value, digit_count);
    end
  endtask

  task automatic test_locked_and_clear();
    press(4'h3);
    checks++;
    if (entry_error !== 1'b1 || value !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL locked_reject got err=%b value=%h cnt=%0d required err=1 value=1234 cnt=4",
               entry_error, value, digit_count);
    end
    @(negedge clk);
    clear = 1'b1; key_valid = 1'b1; key_code = 4'h3;
    @(negedge clk);
    clear = 1'b0; key_valid = 1'b0;
    checks++;
    if (value !== 16'h0000 || digit_count !== 3'd0 || entry_error !== 1'b0) begin
      errors++;
      $display("FAIL clear_drops_key got value=%h cnt=%0d err=%b required 0000/0 err=0",
               value, digit_count, entry_error);
    end
    press(4'h3);
    checks++;
    if (value !== 16'h0003 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL after_clear_key got %h/%0d required 0003/1", value, digit_count);
    end
    do_clear();
  endtask

  task automatic test_backspace();
    press(4'h5); press(4'h6); press(4'hE);
    checks++;
    if (value !== 16'h0005 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL backspace got %h/%0d required 0005/1", value, digit_count);
    end
    press(4'h7); press(4'h8); press(4'h9);
    checks++;
    if (value !== 16'h5789 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL back_refill got %h/%0d required 5789/4", value, digit_count);
    end
    press(4'hE);
    checks++;
    if (value !== 16'h0578 || digit_count !== 3'd3) begin
      errors++;
      $display("FAIL back_from_full got %h/%0d required 0578/3", value, digit_count);
    end
    press(4'h9); press(4'hF);
    checks++;
    if (value_ready !== 1'b1 || value !== 16'h5789) begin
      errors++;
      $display("FAIL back_submit got rdy=%b value=%h required rdy=1 value=5789", value_ready, value);
    end
    do_clear();
  endtask

  task automatic test_errors();
    press(4'hE);
    checks++;
    if (entry_error !== 1'b1 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL back_in_idle got err=%b cnt=%0d required err=1 cnt=0", entry_error, digit_count);
    end
    press(4'h1); press(4'h2); press(4'hF);
    checks++;
    if (entry_error !== 1'b1 || value_ready !== 1'b0 || digit_count !== 3'd2 || value !== 16'h0012) begin
      errors++;
      $display("FAIL early_enter got err=%b rdy=%b cnt=%0d value=%h required err=1 rdy=0 cnt=2 value=0012",
               entry_error, value_ready, digit_count, value);
    end
    press(4'h3); press(4'h4); press(4'h5);
    checks++;
    if (entry_error !== 1'b1 || value !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL fifth_digit got err=%b value=%h cnt=%0d required err=1 value=1234 cnt=4",
               entry_error, value, digit_count);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'h9;
    @(negedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (value !== 16'h0099 || digit_count !== 3'd2) begin
      errors++;
      $display("FAIL held_strobe got %h/%0d required 0099/2", value, digit_count);
    end
    do_clear();
  endtask

  task automatic test_timeout();
    logic saw;
    press(4'hA);
    saw = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      saw = saw | timeout;
    end
    checks++;
    if (saw !== 1'b0 || digit_count !== 3'd1 || value !== 16'h000A) begin
      errors++;
      $display("FAIL timeout_early got seen=%b cnt=%0d value=%h required seen=0 cnt=1 value=000a",
               saw, digit_count, value);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || digit_count !== 3'd0 || value !== 16'h0000 || entry_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got tmo=%b cnt=%0d value=%h err=%b required tmo=1 cnt=0 value=0000 err=0",
               timeout, digit_count, value, entry_error);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got %b required 0", timeout);
    end
    press(4'hE);
    checks++;
    if (entry_error !== 1'b1 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL timeout_idle got err=%b cnt=%0d required err=1 cnt=0", entry_error, digit_count);
    end
    press(4'hA);
    for (int i = 0; i < 97; i++) @(negedge clk);
    press(4'hB);
    saw = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      saw = saw | timeout;
    end
    checks++;
    if (saw !== 1'b0 || digit_count !== 3'd2 || value !== 16'h00AB) begin
      errors++;
      $display("FAIL timeout_restart got seen=%b cnt=%0d value=%h required seen=0 cnt=2 value=00ab",
               saw, digit_count, value);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL timeout_second got tmo=%b cnt=%0d required tmo=1 cnt=0", timeout, digit_count);
    end
  endtask

  task automatic test_async_reset_and_enable();
    press(4'h1); press(4'h2); press(4'h3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (value !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%0d required 0000/0", value, digit_count);
    end
    @(negedge clk);
    rst = 1'b1;
    press(4'h7);
    checks++;
    if (value !== 16'h0007 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_key got %h/%0d required 0007/1", value, digit_count);
    end
    press(4'h1); press(4'h2); press(4'h3);
    @(negedge clk);
    enable = 1'b0; key_valid = 1'b1; key_code = 4'h5;
    @(negedge clk);
    enable = 1'b1; key_valid = 1'b0;
    checks++;
    if (value !== 16'h0000 || digit_count !== 3'd0 || entry_error !== 1'b0) begin
      errors++;
      $display("FAIL enable_low got value=%h cnt=%0d err=%b required 0000/0 err=0",
               value, digit_count, entry_error);
    end
    press(4'h7);
    checks++;
    if (value !== 16'h0007 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL enable_idle got %h/%0d required 0007/1", value, digit_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish before 200us");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_entry();
    test_locked_and_clear();
    test_backspace();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_async_reset_and_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
